// File: rtl/rgmii_rx_multispeed_adapter_if.sv
// Bus bundle for the RGMII->GMII receive adapter: DDR-captured RGMII inputs,
// GMII byte stream with clock enable, filtered in-band status and statistics.
interface rgmii_rx_multispeed_adapter_if #(
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       speed;
    logic [3:0]       rx_d_rise;
    logic [3:0]       rx_d_fall;
    logic             rx_ctl_rise;
    logic             rx_ctl_fall;
    logic [7:0]       gmii_rxd;
    logic             gmii_rx_dv;
    logic             gmii_rx_er;
    logic             gmii_ce;
    logic             link_up;
    logic [1:0]       link_speed;
    logic             full_duplex;
    logic             status_change;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    // PHY/source side
    modport master (
        output speed, rx_d_rise, rx_d_fall, rx_ctl_rise, rx_ctl_fall,
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_ce,
        input  link_up, link_speed, full_duplex, status_change, frame_cnt, err_cnt
    );

    // Adapter side
    modport slave (
        input  speed, rx_d_rise, rx_d_fall, rx_ctl_rise, rx_ctl_fall,
        output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_ce,
        output link_up, link_speed, full_duplex, status_change, frame_cnt, err_cnt
    );
endinterface

// File: rtl/rgmii_rx_multispeed_adapter.sv
// Technology-independent RGMII->GMII receive adapter (10/100/1000) with ce strobe and
// filtered in-band status. Define RGMII_RX_STATS_EN to build the frame/error counters.
module rgmii_rx_multispeed_adapter #(
    parameter int unsigned STATUS_FILTER = 4,
    parameter int unsigned CNT_W         = 16
) (
    input logic                          clk,
    input logic                          rst,
    rgmii_rx_multispeed_adapter_if.slave bus
);
    localparam int unsigned FILT_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    logic [1:0] state, stateNext;
    logic [1:0] speedQ, speedNext;
    logic [3:0] lowNib, lowNibNext;
    logic       errAcc, errAccNext;
    logic       ceTog;
    logic [7:0] rxdQ, rxdNext;
    logic       dvQ, dvNext;
    logic       erQ, erNext;
    logic       ceQ, ceNext;
    logic       dv, er, gigMode;

    assign dv      = bus.rx_ctl_rise;
    assign er      = bus.rx_ctl_rise ^ bus.rx_ctl_fall;
    assign gigMode = (speedQ == 2'b10) || (speedQ == 2'b11);

    // Next-state and next-output for the byte path
    always_comb begin
        stateNext  = state;
        speedNext  = speedQ;
        lowNibNext = lowNib;
        errAccNext = errAcc;
        rxdNext    = rxdQ;
        dvNext     = dvQ;
        erNext     = erQ;
        ceNext     = 1'b0;
        if (state == IDLE && !dv) speedNext = bus.speed;
        if (gigMode) begin
            stateNext = IDLE;
            rxdNext   = {bus.rx_d_fall, bus.rx_d_rise};
            dvNext    = dv;
            erNext    = er;
            ceNext    = 1'b1;
        end else begin
            case (state)
                HIGH: begin
                    ceNext = 1'b1;
                    dvNext = 1'b1;
                    if (dv) begin
                        rxdNext   = {bus.rx_d_rise, lowNib};
                        erNext    = errAcc | er;
                        stateNext = LOW;
                    end else begin
                        // Odd nibble count: flush the lone nibble flagged as errored
                        rxdNext   = {4'h0, lowNib};
                        erNext    = 1'b1;
                        stateNext = IDLE;
                    end
                end
                default: begin
                    if (dv) begin
                        lowNibNext = bus.rx_d_rise;
                        errAccNext = er;
                        stateNext  = HIGH;
                        if (state == IDLE) begin
                            rxdNext = 8'h00;
                            dvNext  = 1'b0;
                            erNext  = 1'b0;
                        end
                    end else begin
                        stateNext = IDLE;
                        rxdNext   = 8'h00;
                        dvNext    = 1'b0;
                        erNext    = er;
                        ceNext    = ceTog;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            speedQ <= 2'b00;
            lowNib <= 4'h0;
            errAcc <= 1'b0;
            ceTog  <= 1'b0;
            rxdQ   <= 8'h00;
            dvQ    <= 1'b0;
            erQ    <= 1'b0;
            ceQ    <= 1'b0;
        end else begin
            state  <= stateNext;
            speedQ <= speedNext;
            lowNib <= lowNibNext;
            errAcc <= errAccNext;
            ceTog  <= ~ceTog;
            rxdQ   <= rxdNext;
            dvQ    <= dvNext;
            erQ    <= erNext;
            ceQ    <= ceNext;
        end
    end

    assign bus.gmii_rxd   = rxdQ;
    assign bus.gmii_rx_dv = dvQ;
    assign bus.gmii_rx_er = erQ;
    assign bus.gmii_ce    = ceQ;

    // In-band status filter; the counter freezes during frames and error-carrier cycles
    logic [3:0]        cand, candNext;
    logic [FILT_W-1:0] filtCnt, filtNext;
    logic              linkQ, duplexQ, chgQ;
    logic [1:0]        linkSpdQ;
    logic              sampleEn, doUpdate;

    assign sampleEn = !dv && !er;

    always_comb begin
        candNext = cand;
        filtNext = filtCnt;
        if (sampleEn) begin
            if (bus.rx_d_rise == cand) begin
                if (filtCnt < FILT_W'(STATUS_FILTER)) filtNext = filtCnt + FILT_W'(1);
            end else begin
                candNext = bus.rx_d_rise;
                filtNext = FILT_W'(1);
            end
        end
        doUpdate = sampleEn && (filtNext == FILT_W'(STATUS_FILTER)) &&
                   (candNext != {duplexQ, linkSpdQ, linkQ});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand     <= 4'h0;
            filtCnt  <= '0;
            linkQ    <= 1'b0;
            linkSpdQ <= 2'b00;
            duplexQ  <= 1'b0;
            chgQ     <= 1'b0;
        end else begin
            cand    <= candNext;
            filtCnt <= filtNext;
            chgQ    <= doUpdate;
            if (doUpdate) begin
                linkQ    <= candNext[0];
                linkSpdQ <= candNext[2:1];
                duplexQ  <= candNext[3];
            end
        end
    end

    assign bus.link_up       = linkQ;
    assign bus.link_speed    = linkSpdQ;
    assign bus.full_duplex   = duplexQ;
    assign bus.status_change = chgQ;

`ifdef RGMII_RX_STATS_EN
    logic [CNT_W-1:0] frameCnt, errCnt;
    logic             dvD, errSeen;

    // Count on the registered dv falling edge; errSeen spans the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            frameCnt <= '0;
            errCnt   <= '0;
            dvD      <= 1'b0;
            errSeen  <= 1'b0;
        end else begin
            dvD <= dvQ;
            if (dvD && !dvQ) begin
                if (frameCnt != '1) frameCnt <= frameCnt + CNT_W'(1);
                if (errSeen && errCnt != '1) errCnt <= errCnt + CNT_W'(1);
                errSeen <= 1'b0;
            end else if (dvQ && erQ) begin
                errSeen <= 1'b1;
            end
        end
    end

    assign bus.frame_cnt = frameCnt;
    assign bus.err_cnt   = errCnt;
`else
    assign bus.frame_cnt = '0;
    assign bus.err_cnt   = '0;
`endif
endmodule
